bram_port_ctrl: RTL and testbench

- Sequences one simple dual-port `bram` instance (1 read port, 1 write port, registered read data, read-first on address collision) inside the L1 cache.
- Zero-fills the array after reset and on demand.
- Gates requester read/write handshakes and issues one-cycle-latency read responses.
- Makes a same-cycle, same-address read+write appear write-first to the requester.

---
 rtl/bram_port_ctrl_if.sv | 28 ++
 rtl/bram_port_ctrl.sv | 114 +++++++++++
 tb/tb_bram_port_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_ctrl_if.sv
// Requester-side bus of the L1 cache array controller: clear request,
// read handshake with a registered response, and write handshake.
interface bram_port_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  clr_req;
  logic                  busy;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output clr_req, rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  busy, rd_ready, rd_valid, rd_data, wr_ready
  );

  modport slave (
    input  clr_req, rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output busy, rd_ready, rd_valid, rd_data, wr_ready
  );
endinterface

// File: rtl/bram_port_ctrl.sv
// Port sequencer for one simple dual-port bram (registered read, read-first
// on collision). Zero-fills the array after reset and on clr_req, gates the
// requester handshakes, and turns a same-cycle same-address read+write into
// write-first behaviour by forwarding the write data into the response.
module bram_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  bram_port_ctrl_if.slave       req,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  output logic [ADDR_WIDTH-1:0] bram_waddr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  port_open;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  collide;
  logic                  vld_p1;
  logic                  fwd_p1;
  logic [DATA_WIDTH-1:0] fwd_data_p1;

  // Requests are taken only in RUN and never in a cycle that asks for a clear.
  assign port_open = (state == RUN) && !req.clr_req;
  assign rd_acc    = req.rd_req && port_open;
  assign wr_acc    = req.wr_req && port_open;
  assign collide   = rd_acc && wr_acc && (req.rd_addr == req.wr_addr);

  // State register and sweep counter; reset restarts the sweep from address 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: sweep every address once, then run until a clear is requested.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + ADDR_WIDTH'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (req.clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: the sweep owns the write port in CLEAR, the requester in RUN.
  always_comb begin
    req.busy     = 1'b1;
    req.rd_ready = 1'b0;
    req.wr_ready = 1'b0;
    bram_we      = 1'b1;
    bram_waddr   = cnt;
    bram_din     = '0;
    bram_raddr   = req.rd_addr;
    if (state == RUN) begin
      req.busy     = 1'b0;
      req.rd_ready = !req.clr_req;
      req.wr_ready = !req.clr_req;
      bram_we      = wr_acc;
      bram_waddr   = req.wr_addr;
      bram_din     = req.wr_data;
    end
  end

  // ---- stage p0 -> p1: read response and collision forward ----
  // The bram returns old data on a same-address collision, so the write data
  // is captured here and substituted for bram_dout on the response cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p1      <= 1'b0;
      fwd_p1      <= 1'b0;
      fwd_data_p1 <= '0;
    end else begin
      vld_p1      <= rd_acc;
      fwd_p1      <= collide;
      if (collide) begin
        fwd_data_p1 <= req.wr_data;
      end
    end
  end

  assign req.rd_valid = vld_p1;
  assign req.rd_data  = fwd_p1 ? fwd_data_p1 : bram_dout;

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Bench for bram_port_ctrl with a behavioural read-first bram, a shadow
// memory of write-first requester semantics and a response scoreboard.
module tb_bram_port_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic poison = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_port_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) req_if ();

  logic [AW-1:0] bram_raddr;
  logic [AW-1:0] bram_waddr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic [DW-1:0] bram_dout;

  bram_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req_if),
    .bram_raddr (bram_raddr),
    .bram_waddr (bram_waddr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
    .bram_dout  (bram_dout)
  );

  // Simple dual-port bram: registered read, read-first; poison fills garbage.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (poison) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hBAD0_0000 | i;
    end else if (bram_we) begin
      mem[bram_waddr] <= bram_din;
    end
    bram_dout <= mem[bram_raddr];
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          sb [$];
  logic [DW-1:0] exp_mem [DEPTH];

  // Monitor: compare responses against the scoreboard, then record new
  // accepted requests into the shadow memory model.
  always @(negedge clk) begin : mon
    rsp_t          e;
    logic [DW-1:0] x;
    if (!rstn) begin
      sb.delete();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    end else begin
      if (req_if.rd_valid) begin
        if (sb.size() == 0) begin
          chk_eq("rd_valid_spurious", req_if.rd_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk_eq("rd_latency", cyc, e.cyc);
          chk_eq("rd_data", req_if.rd_data, e.data);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        chk_eq("rd_valid_missing", req_if.rd_valid, 1'b1);
        void'(sb.pop_front());
      end
      if (req_if.rd_req && req_if.rd_ready) begin
        if (req_if.wr_req && req_if.wr_ready && req_if.wr_addr == req_if.rd_addr)
          x = req_if.wr_data;
        else
          x = exp_mem[req_if.rd_addr];
        sb.push_back('{cyc + 1, x});
      end
      if (req_if.wr_req && req_if.wr_ready) exp_mem[req_if.wr_addr] = req_if.wr_data;
      if (req_if.clr_req) begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      end
    end
  end

  task automatic drive(input logic rr, input logic [AW-1:0] ra, input logic wr,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic clr);
    @(posedge clk);
    #1;
    req_if.rd_req  = rr;
    req_if.rd_addr = ra;
    req_if.wr_req  = wr;
    req_if.wr_addr = wa;
    req_if.wr_data = wd;
    req_if.clr_req = clr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Expects to be entered during the cycle before sweep cycle 0 is sampled.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk_eq({tag, "_busy"}, req_if.busy, 1'b1);
      chk_eq({tag, "_we"}, bram_we, 1'b1);
      chk_eq({tag, "_waddr"}, bram_waddr, i);
      chk_eq({tag, "_din"}, bram_din, '0);
      chk_eq({tag, "_ready"}, {req_if.rd_ready, req_if.wr_ready}, 2'b00);
    end
    @(negedge clk);
    chk_eq({tag, "_busy_end"}, req_if.busy, 1'b0);
    chk_eq({tag, "_ready_end"}, {req_if.rd_ready, req_if.wr_ready}, 2'b11);
  endtask

  initial begin
    req_if.rd_req  = 1'b0;
    req_if.rd_addr = '0;
    req_if.wr_req  = 1'b0;
    req_if.wr_addr = '0;
    req_if.wr_data = '0;
    req_if.clr_req = 1'b0;

    #2;
    chk_eq("rst_busy", req_if.busy, 1'b1);
    chk_eq("rst_ready", {req_if.rd_ready, req_if.wr_ready}, 2'b00);
    chk_eq("rst_rd_valid", req_if.rd_valid, 1'b0);
    @(posedge clk);
    #1 poison = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    sweep_check("sweep_rst");

    // read of a swept address
    drive(1'b1, 4'd7, 1'b0, '0, '0, 1'b0);
    idle();
    // write then read next cycle
    drive(1'b0, '0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0);
    drive(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
    idle();
    // same-cycle collision forwards the new data
    drive(1'b0, '0, 1'b1, 4'd5, 32'h11, 1'b0);
    drive(1'b1, 4'd5, 1'b1, 4'd5, 32'h22, 1'b0);
    drive(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    // read then write returns the old data
    drive(1'b0, '0, 1'b1, 4'd5, 32'h11, 1'b0);
    drive(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 4'd5, 32'h22, 1'b0);
    drive(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    // different addresses in the same cycle
    drive(1'b0, '0, 1'b1, 4'd2, 32'h77, 1'b0);
    drive(1'b1, 4'd2, 1'b1, 4'd9, 32'h99, 1'b0);
    drive(1'b1, 4'd9, 1'b0, '0, '0, 1'b0);
    // random traffic over a few addresses to provoke collisions
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom, 1'b0);
    end
    // clear in RUN; the read in the preceding cycle still completes
    drive(1'b0, '0, 1'b1, 4'd1, 32'hAB, 1'b0);
    drive(1'b1, 4'd1, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 4'd1, 1'b1, 4'd1, 32'h55, 1'b1);
    @(negedge clk);
    chk_eq("clr_ready", {req_if.rd_ready, req_if.wr_ready}, 2'b00);
    chk_eq("clr_we", bram_we, 1'b0);
    chk_eq("clr_busy", req_if.busy, 1'b0);
    idle();
    sweep_check("sweep_clr");
    drive(1'b1, 4'd1, 1'b0, '0, '0, 1'b0);
    idle();
    idle();
    // reset at sweep cycle 6 restarts the sweep
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle();
    @(negedge clk);
    chk_eq("mid_waddr", bram_waddr, 0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk_eq("mid_waddr", bram_waddr, i);
    end
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk_eq("mid_rst_busy", req_if.busy, 1'b1);
    chk_eq("mid_rst_waddr", bram_waddr, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    sweep_check("sweep_mid");
    drive(1'b1, 4'd3, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 4'd7, 1'b0, '0, '0, 1'b0);
    idle();
    idle();
    idle();
    @(negedge clk);
    chk_eq("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
